// File: rtl/sim_dtm_bridge.sv
`default_nettype none
// ============================================================================
// Module  : sim_dtm_bridge
// Brief   : Host-to-debug-bus bridge. Requests queue in a FIFO and a
//           four-state FSM issues them one at a time. An optional response
//           watchdog is built when SIM_DTM_TIMEOUT_EN is defined.
// Rev     : 1.0 - initial release
// ============================================================================
module sim_dtm_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clock,
  input  logic                       reset_n,
  // host request channel
  input  logic                       host_req_valid,
  output logic                       host_req_ready,
  input  logic [1:0]                 host_req_op,
  input  logic [ADDR_W-1:0]          host_req_addr,
  input  logic [DATA_W-1:0]          host_req_data,
  // debug-bus request channel
  output logic                       dbg_req_valid,
  input  logic                       dbg_req_ready,
  output logic [1:0]                 dbg_req_op,
  output logic [ADDR_W-1:0]          dbg_req_addr,
  output logic [DATA_W-1:0]          dbg_req_data,
  // debug-bus response channel
  input  logic                       dbg_resp_valid,
  output logic                       dbg_resp_ready,
  input  logic [1:0]                 dbg_resp_resp,
  input  logic [DATA_W-1:0]          dbg_resp_data,
  // host response channel
  output logic                       host_resp_valid,
  input  logic                       host_resp_ready,
  output logic [1:0]                 host_resp_resp,
  output logic [DATA_W-1:0]          host_resp_data,
  // status
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [1:0]          req_op_q, req_op_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_data_q, req_data_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic [1:0]          fifo_op_mem   [DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_mem [DEPTH];
  logic [DATA_W-1:0]   fifo_data_mem [DEPTH];

  logic                w_push;
  logic                w_pop;

`ifdef SIM_DTM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0]     wd_q, wd_d;
`endif

  // Ready is purely occupancy based; a same-cycle pop never frees a full slot.
  assign host_req_ready = reset_n && (count_q != FULL_CNT);

  always_comb begin
    w_push   = host_req_valid && host_req_ready &&
               ((host_req_op == 2'd1) || (host_req_op == 2'd2));
    w_pop    = (state_q == S_IDLE) && (count_q != '0);
    wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset: entries are only read after being written.
  always_ff @(posedge clock) begin
    if (w_push) begin
      fifo_op_mem[wr_ptr_q]   <= host_req_op;
      fifo_addr_mem[wr_ptr_q] <= host_req_addr;
      fifo_data_mem[wr_ptr_q] <= host_req_data;
    end
  end

  always_comb begin
    state_d         = state_q;
    req_op_d        = req_op_q;
    req_addr_d      = req_addr_q;
    req_data_d      = req_data_q;
    rsp_resp_d      = rsp_resp_q;
    rsp_data_d      = rsp_data_q;
    dbg_req_valid   = 1'b0;
    dbg_resp_ready  = 1'b0;
    host_resp_valid = 1'b0;
`ifdef SIM_DTM_TIMEOUT_EN
    wd_d            = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_pop) begin
          req_op_d   = fifo_op_mem[rd_ptr_q];
          req_addr_d = fifo_addr_mem[rd_ptr_q];
          req_data_d = fifo_data_mem[rd_ptr_q];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dbg_req_valid = 1'b1;
        if (dbg_req_ready) begin
          state_d = S_WAIT;
`ifdef SIM_DTM_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      S_WAIT: begin
        dbg_resp_ready = 1'b1;
        // A real response wins over a watchdog expiry in the same cycle.
        if (dbg_resp_valid) begin
          rsp_resp_d = dbg_resp_resp;
          rsp_data_d = dbg_resp_data;
          state_d    = S_RETURN;
        end
`ifdef SIM_DTM_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          rsp_resp_d = 2'b11;
          rsp_data_d = '0;
          state_d    = S_RETURN;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_RETURN: begin
        host_resp_valid = 1'b1;
        if (host_resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      req_op_q   <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      rsp_resp_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      req_op_q   <= req_op_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      rsp_resp_q <= rsp_resp_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef SIM_DTM_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  assign dbg_req_op     = req_op_q;
  assign dbg_req_addr   = req_addr_q;
  assign dbg_req_data   = req_data_q;
  assign host_resp_resp = rsp_resp_q;
  assign host_resp_data = rsp_data_q;
  assign count          = count_q;
  assign busy           = (state_q != S_IDLE) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_sim_dtm_bridge.sv
`default_nettype none
// Testbench for sim_dtm_bridge: directed scenarios plus randomized traffic
// checked against a queue-based transaction model.
module tb_sim_dtm_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int TMO = 16;

  typedef logic [65:0] req_t;   // {op, addr, data}
  typedef logic [33:0] rsp_t;   // {resp, data}

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          host_req_valid = 1'b0;
  logic          host_req_ready;
  logic [1:0]    host_req_op = 2'd0;
  logic [AW-1:0] host_req_addr = '0;
  logic [DW-1:0] host_req_data = '0;
  logic          dbg_req_valid;
  logic          dbg_req_ready = 1'b0;
  logic [1:0]    dbg_req_op;
  logic [AW-1:0] dbg_req_addr;
  logic [DW-1:0] dbg_req_data;
  logic          dbg_resp_valid = 1'b0;
  logic          dbg_resp_ready;
  logic [1:0]    dbg_resp_resp = 2'd0;
  logic [DW-1:0] dbg_resp_data = '0;
  logic          host_resp_valid;
  logic          host_resp_ready = 1'b0;
  logic [1:0]    host_resp_resp;
  logic [DW-1:0] host_resp_data;
  logic [2:0]    count;
  logic          busy;

  sim_dtm_bridge #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_op(host_req_op), .host_req_addr(host_req_addr), .host_req_data(host_req_data),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_op(dbg_req_op), .dbg_req_addr(dbg_req_addr), .dbg_req_data(dbg_req_data),
    .dbg_resp_valid(dbg_resp_valid), .dbg_resp_ready(dbg_resp_ready),
    .dbg_resp_resp(dbg_resp_resp), .dbg_resp_data(dbg_resp_data),
    .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
    .host_resp_resp(host_resp_resp), .host_resp_data(host_resp_data),
    .count(count), .busy(busy)
  );

  always #5 clock = ~clock;

  int   tests_run = 0;
  int   tests_failed = 0;
  bit   rnd_bus = 1'b0;
  int   waited = 0;
  int   outstanding = 0;
  bit   in_wait = 1'b0;
  bit   resp_pend = 1'b0;
  req_t acc_log[$];
  req_t dbg_log[$];
  rsp_t sent_log[$];
  rsp_t host_log[$];

  task automatic clear_model();
    acc_log.delete(); dbg_log.delete(); sent_log.delete(); host_log.delete();
    outstanding = 0; in_wait = 0; resp_pend = 0; waited = 0;
  endtask

  // Called at a negedge with inputs for the coming edge already driven:
  // records every handshake that edge will complete, then advances.
  task automatic tick();
    if (rnd_bus) begin
      dbg_req_ready   = ($urandom_range(0, 1) == 1);
      dbg_resp_valid  = (waited >= 6) || ($urandom_range(0, 2) == 0);
      dbg_resp_resp   = 2'($urandom_range(0, 3));
      dbg_resp_data   = $urandom();
      host_resp_ready = ($urandom_range(0, 2) != 0);
    end
    if (host_req_valid && host_req_ready) begin
      acc_log.push_back({host_req_op, host_req_addr, host_req_data});
      if (host_req_op == 2'd1 || host_req_op == 2'd2) outstanding++;
    end
    if (dbg_req_valid && dbg_req_ready) begin
      dbg_log.push_back({dbg_req_op, dbg_req_addr, dbg_req_data});
      in_wait = 1;
    end
    if (dbg_resp_valid && dbg_resp_ready) begin
      sent_log.push_back({dbg_resp_resp, dbg_resp_data});
      in_wait = 0; resp_pend = 1; waited = 0;
    end else if (dbg_resp_ready) begin
      waited++;
    end
    if (host_resp_valid && host_resp_ready) begin
      host_log.push_back({host_resp_resp, host_resp_data});
      resp_pend = 0; outstanding--;
    end
    @(negedge clock);
  endtask

  task automatic push_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                          output bit ok);
    int n = 0;
    host_req_valid = 0;
    while (!host_req_ready && n < 300) begin tick(); n++; end
    ok = host_req_ready;
    host_req_valid = 1; host_req_op = op; host_req_addr = a; host_req_data = d;
    tick();
    host_req_valid = 0;
  endtask

  task automatic drain(input int budget, output bit ok);
    int n = 0;
    while ((busy || outstanding != 0) && n < budget) begin tick(); n++; end
    ok = !busy && (outstanding == 0);
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({host_req_ready, dbg_req_valid, dbg_resp_ready, host_resp_valid, busy} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b required 00000",
               {host_req_ready, dbg_req_valid, dbg_resp_ready, host_resp_valid, busy});
    end
    tests_run++;
    if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d required 0", count); end
    reset_n = 1;
    @(negedge clock);
    tests_run++;
    if (host_req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b required 1", host_req_ready); end
  endtask

  task automatic test_single_write();
    bit ok;
    clear_model(); rnd_bus = 0;
    dbg_req_ready = 1; host_resp_ready = 1; dbg_resp_valid = 0;
    push_req(2'd2, 32'h10, 32'hDEADBEEF, ok);
    tests_run++;
    if ({dbg_req_valid, count} !== {1'b0, 3'd1}) begin
      tests_failed++; $display("FAIL write_edge_n: got valid=%b count=%0d required valid=0 count=1", dbg_req_valid, count);
    end
    tick();
    tests_run++;
    if ({dbg_req_valid, dbg_req_op, dbg_req_addr, dbg_req_data} !== {1'b1, 2'd2, 32'h10, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL write_issue: got v=%b op=%0d a=%h d=%h required v=1 op=2 a=10 d=deadbeef",
               dbg_req_valid, dbg_req_op, dbg_req_addr, dbg_req_data);
    end
    tick();
    tests_run++;
    if ({dbg_req_valid, dbg_resp_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL write_wait: got req_v=%b resp_rdy=%b required 0 1", dbg_req_valid, dbg_resp_ready);
    end
    tick(); tick();
    dbg_resp_valid = 1; dbg_resp_resp = 2'd0; dbg_resp_data = 32'hCAFE0001;
    tick();
    dbg_resp_valid = 0;
    tests_run++;
    if ({host_resp_valid, host_resp_resp, host_resp_data} !== {1'b1, 2'd0, 32'hCAFE0001}) begin
      tests_failed++;
      $display("FAIL write_resp: got v=%b r=%0d d=%h required v=1 r=0 d=cafe0001",
               host_resp_valid, host_resp_resp, host_resp_data);
    end
    tick();
    tests_run++;
    if ({busy, host_resp_valid} !== 2'b00 || dbg_log.size() != 1 || host_log.size() != 1) begin
      tests_failed++;
      $display("FAIL write_done: got busy=%b reqs=%0d resps=%0d required 0 1 1", busy, dbg_log.size(), host_log.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    clear_model(); rnd_bus = 0;
    dbg_req_ready = 0; host_resp_ready = 1; dbg_resp_valid = 0;
    for (int i = 0; i < 5; i++) begin
      push_req(2'd1, 32'h100 + i, $urandom(), ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL bp_push: request %0d got ready=0 required 1", i); end
    end
    tests_run++;
    if ({count, host_req_ready, dbg_req_valid, dbg_req_addr} !== {3'd4, 1'b0, 1'b1, 32'h100}) begin
      tests_failed++;
      $display("FAIL bp_full: got count=%0d rdy=%b req_v=%b addr=%h required 4 0 1 100",
               count, host_req_ready, dbg_req_valid, dbg_req_addr);
    end
    host_req_valid = 1; host_req_op = 2'd1; host_req_addr = 32'h105; host_req_data = $urandom();
    repeat (3) tick();
    tests_run++;
    if (count !== 3'd4 || acc_log.size() != 5) begin
      tests_failed++; $display("FAIL bp_hold: got count=%0d accepted=%0d required 4 5", count, acc_log.size());
    end
    rnd_bus = 1; n = 0;
    while (acc_log.size() < 6 && n < 300) begin tick(); n++; end
    host_req_valid = 0;
    drain(2000, ok);
    tests_run++;
    if (!ok || dbg_log.size() != 6 || host_log.size() != 6) begin
      tests_failed++;
      $display("FAIL bp_complete: got idle=%b reqs=%0d resps=%0d required 1 6 6", ok, dbg_log.size(), host_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (dbg_log[i] !== acc_log[i] || dbg_log[i][63:32] !== 32'h100 + i) begin
          tests_failed++; $display("FAIL bp_order[%0d]: got %h required %h", i, dbg_log[i], acc_log[i]);
        end
        tests_run++;
        if (host_log[i] !== sent_log[i]) begin
          tests_failed++; $display("FAIL bp_resp[%0d]: got %h required %h", i, host_log[i], sent_log[i]);
        end
      end
    end
  endtask

  task automatic test_nop_filter();
    bit ok;
    logic [1:0] ops [4];
    ops[0] = 2'd0; ops[1] = 2'd1; ops[2] = 2'd3; ops[3] = 2'd2;
    clear_model(); rnd_bus = 1;
    for (int i = 0; i < 4; i++) push_req(ops[i], 32'(i), 32'hA0 + i, ok);
    drain(1000, ok);
    tests_run++;
    if (!ok || acc_log.size() != 4 || dbg_log.size() != 2 || host_log.size() != 2) begin
      tests_failed++;
      $display("FAIL nop_count: got idle=%b acc=%0d reqs=%0d resps=%0d required 1 4 2 2",
               ok, acc_log.size(), dbg_log.size(), host_log.size());
    end else begin
      tests_run++;
      if (dbg_log[0] !== {2'd1, 32'h1, 32'hA1} || dbg_log[1] !== {2'd2, 32'h3, 32'hA3}) begin
        tests_failed++; $display("FAIL nop_reqs: got %h %h required op1@1 op2@3", dbg_log[0], dbg_log[1]);
      end
      tests_run++;
      if (host_log[0] !== sent_log[0] || host_log[1] !== sent_log[1]) begin
        tests_failed++; $display("FAIL nop_resps: got %h %h required %h %h", host_log[0], host_log[1], sent_log[0], sent_log[1]);
      end
    end
  endtask

  task automatic test_host_stall();
    bit ok;
    int n = 0;
    clear_model(); rnd_bus = 0;
    dbg_req_ready = 1; host_resp_ready = 0; dbg_resp_valid = 0;
    push_req(2'd1, 32'h20, 32'h0, ok);
    push_req(2'd2, 32'h21, 32'h99, ok);
    while (!dbg_resp_ready && n < 50) begin tick(); n++; end
    tests_run++;
    if (!dbg_resp_ready) begin tests_failed++; $display("FAIL stall_wait: got resp_ready=0 required 1"); end
    dbg_resp_valid = 1; dbg_resp_resp = 2'd1; dbg_resp_data = 32'h55;
    tick();
    dbg_resp_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if ({host_resp_valid, host_resp_resp, host_resp_data, dbg_req_valid} !== {1'b1, 2'd1, 32'h55, 1'b0}) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got v=%b r=%0d d=%h req_v=%b required 1 1 55 0",
                 i, host_resp_valid, host_resp_resp, host_resp_data, dbg_req_valid);
      end
      tick();
    end
    tests_run++;
    if (dbg_log.size() != 1) begin tests_failed++; $display("FAIL stall_noissue: got %0d reqs required 1", dbg_log.size()); end
    host_resp_ready = 1; rnd_bus = 1;
    drain(1000, ok);
    tests_run++;
    if (!ok || host_log.size() != 2 || dbg_log.size() != 2) begin
      tests_failed++; $display("FAIL stall_drain: got idle=%b resps=%0d required 1 2", ok, host_log.size());
    end else begin
      tests_run++;
      if (host_log[0] !== {2'd1, 32'h55} || dbg_log[1] !== acc_log[1]) begin
        tests_failed++; $display("FAIL stall_values: got %h %h required %h %h", host_log[0], dbg_log[1], {2'd1, 32'h55}, acc_log[1]);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n = 0;
    clear_model(); rnd_bus = 0;
    dbg_req_ready = 1; host_resp_ready = 0; dbg_resp_valid = 0;
    push_req(2'd1, 32'h40, 32'h0, ok);
    while (!dbg_resp_ready && n < 50) begin tick(); n++; end
    tests_run++;
    if (!dbg_resp_ready) begin tests_failed++; $display("FAIL tmo_wait: got resp_ready=0 required 1"); end
    n = 0;
`ifdef SIM_DTM_TIMEOUT_EN
    while (!host_resp_valid && n < 100) begin tick(); n++; end
    tests_run++;
    if (n != TMO) begin tests_failed++; $display("FAIL tmo_cycles: got %0d required %0d", n, TMO); end
    tests_run++;
    if ({host_resp_valid, host_resp_resp, host_resp_data} !== {1'b1, 2'b11, 32'h0}) begin
      tests_failed++; $display("FAIL tmo_resp: got v=%b r=%0d d=%h required 1 3 0", host_resp_valid, host_resp_resp, host_resp_data);
    end
`else
    begin
      bit seen = 0;
      repeat (1000) begin tick(); if (host_resp_valid) seen = 1; end
      tests_run++;
      if (seen) begin tests_failed++; $display("FAIL tmo_none: got response required none in 1000 cycles"); end
    end
    dbg_resp_valid = 1; dbg_resp_resp = 2'd0; dbg_resp_data = 32'h0;
    tick();
    dbg_resp_valid = 0;
`endif
    host_resp_ready = 1;
    drain(200, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL tmo_drain: got busy=%b required 0", busy); end
  endtask

  task automatic test_random();
    bit ok;
    int nreq;
    clear_model(); rnd_bus = 1;
    for (int c = 0; c < 400; c++) begin
      host_req_valid = ($urandom_range(0, 1) == 1);
      host_req_op    = 2'($urandom_range(0, 3));
      host_req_addr  = $urandom();
      host_req_data  = $urandom();
      tick();
      tests_run++;
      if (dbg_resp_ready !== in_wait) begin
        tests_failed++; $display("FAIL rnd_resp_ready@%0d: got %b required %b", c, dbg_resp_ready, in_wait);
      end
      tests_run++;
      if (host_resp_valid !== resp_pend) begin
        tests_failed++; $display("FAIL rnd_host_valid@%0d: got %b required %b", c, host_resp_valid, resp_pend);
      end
      tests_run++;
      if (busy !== (outstanding != 0)) begin
        tests_failed++; $display("FAIL rnd_busy@%0d: got %b required %b", c, busy, outstanding != 0);
      end
      tests_run++;
      if (host_req_ready !== (count != 3'd4)) begin
        tests_failed++; $display("FAIL rnd_ready@%0d: got %b with count=%0d", c, host_req_ready, count);
      end
    end
    host_req_valid = 0;
    drain(2000, ok);
    nreq = 0;
    for (int i = 0; i < acc_log.size(); i++) begin
      if (acc_log[i][65:64] == 2'd1 || acc_log[i][65:64] == 2'd2) begin
        tests_run++;
        if (nreq >= dbg_log.size() || dbg_log[nreq] !== acc_log[i]) begin
          tests_failed++;
          $display("FAIL rnd_req[%0d]: got %h required %h", nreq,
                   (nreq < dbg_log.size()) ? dbg_log[nreq] : 66'h0, acc_log[i]);
        end
        nreq++;
      end
    end
    tests_run++;
    if (!ok || dbg_log.size() != nreq || host_log.size() != nreq || sent_log.size() != nreq) begin
      tests_failed++;
      $display("FAIL rnd_totals: got idle=%b reqs=%0d resps=%0d required 1 %0d %0d", ok, dbg_log.size(), host_log.size(), nreq, nreq);
    end else begin
      for (int i = 0; i < nreq; i++) begin
        tests_run++;
        if (host_log[i] !== sent_log[i]) begin
          tests_failed++; $display("FAIL rnd_resp[%0d]: got %h required %h", i, host_log[i], sent_log[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    clear_model(); rnd_bus = 0;
    dbg_req_ready = 1; host_resp_ready = 1; dbg_resp_valid = 0;
    for (int i = 0; i < 3; i++) push_req(2'd1, 32'h60 + i, 32'h0, ok);
    tests_run++;
    if ({count, dbg_resp_ready} !== {3'd2, 1'b1}) begin
      tests_failed++; $display("FAIL rst_pre: got count=%0d resp_ready=%b required 2 1", count, dbg_resp_ready);
    end
    #2 reset_n = 0;
    #1;
    tests_run++;
    if ({count, dbg_req_valid, dbg_resp_ready, host_resp_valid, host_req_ready, busy} !== 8'b0) begin
      tests_failed++;
      $display("FAIL rst_async: got count=%0d flags=%b required 0 00000", count,
               {dbg_req_valid, dbg_resp_ready, host_resp_valid, host_req_ready, busy});
    end
    @(negedge clock);
    reset_n = 1;
    clear_model();
    dbg_resp_valid = 1; dbg_resp_resp = 2'd0; dbg_resp_data = 32'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if ({host_resp_valid, dbg_resp_ready, dbg_req_valid, busy, count} !== 7'b0) begin
        tests_failed++;
        $display("FAIL rst_after[%0d]: got flags=%b count=%0d required 0000 0", i,
                 {host_resp_valid, dbg_resp_ready, dbg_req_valid, busy}, count);
      end
    end
    dbg_resp_valid = 0;
    tests_run++;
    if (host_log.size() != 0 || dbg_log.size() != 0) begin
      tests_failed++; $display("FAIL rst_abandon: got reqs=%0d resps=%0d required 0 0", dbg_log.size(), host_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_backpressure();
    test_nop_filter();
    test_host_stall();
    test_timeout();
    test_random();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running required completion");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
